// File: rtl/uart_rx_ovs.sv
// Oversampling UART receiver with 3-sample majority vote,
// false-start filtering and parity/framing/break reporting.
module uart_rx_ovs #(
  parameter int DATA_W = 8,
  parameter int OVS    = 16
) (
  input  logic              clk_i,
  input  logic              arst_ni,
  input  logic              tick_i,
  input  logic              cfg_parity_en_i,
  input  logic              cfg_parity_type_i,
  input  logic              cfg_stop_bits_i,
  input  logic              rx_i,
  output logic [DATA_W-1:0] rx_data_o,
  output logic              rx_data_valid_o,
  output logic              rx_parity_err_o,
  output logic              rx_frame_err_o,
  output logic              rx_break_o,
  output logic              rx_busy_o
);

  localparam int CW = $clog2(OVS);
  localparam int BW = $clog2(DATA_W + 1);
  localparam int M  = OVS / 2;

  localparam logic [CW-1:0] LAST = CW'(OVS - 1);
  localparam logic [CW-1:0] MM1  = CW'(M - 1);
  localparam logic [CW-1:0] MM   = CW'(M);
  localparam logic [CW-1:0] MP1  = CW'(M + 1);
  localparam logic [BW-1:0] LBIT = BW'(DATA_W - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP1,
    STOP2,
    WAIT_IDLE
  } state_t;

  state_t state;

  logic              rx_q;
  logic              rxs;
  logic [CW-1:0]     cnt;
  logic [BW-1:0]     bitcnt;
  logic [DATA_W-1:0] shreg;
  logic              par_bit;
  logic              par_en;
  logic              par_type;
  logic              stop2;
  logic              smp0;
  logic              smp1;

  logic vote;
  logic fin;
  logic ferr_c;
  logic perr_c;
  logic brk_c;

  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      rx_q <= 1'b1;
      rxs  <= 1'b1;
    end else begin
      rx_q <= rx_i;
      rxs  <= rx_q;
    end
  end

  assign vote = (smp0 & smp1) | (smp0 & rxs) | (smp1 & rxs);

  // A passing vote in STOP1 with two stop bits defers completion to STOP2
  assign fin = tick_i && cnt == MP1 &&
               ((state == STOP1 && !(stop2 && vote)) ||
                state == STOP2);

  assign ferr_c = ~vote;
  assign perr_c = par_en & (par_bit != (^shreg ^ par_type));
  assign brk_c  = ferr_c & (shreg == '0) & (~par_en | ~par_bit);

  assign rx_busy_o = (state != IDLE);

  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      state           <= IDLE;
      cnt             <= '0;
      bitcnt          <= '0;
      shreg           <= '0;
      par_bit         <= 1'b0;
      par_en          <= 1'b0;
      par_type        <= 1'b0;
      stop2           <= 1'b0;
      smp0            <= 1'b0;
      smp1            <= 1'b0;
      rx_data_o       <= '0;
      rx_data_valid_o <= 1'b0;
      rx_parity_err_o <= 1'b0;
      rx_frame_err_o  <= 1'b0;
      rx_break_o      <= 1'b0;
    end else begin
      rx_data_valid_o <= 1'b0;
      rx_parity_err_o <= 1'b0;
      rx_frame_err_o  <= 1'b0;
      rx_break_o      <= 1'b0;
      if (fin) begin
        rx_data_o       <= shreg;
        rx_data_valid_o <= ~perr_c & ~ferr_c;
        rx_parity_err_o <= perr_c;
        rx_frame_err_o  <= ferr_c;
        rx_break_o      <= brk_c;
        state           <= ferr_c ? WAIT_IDLE : IDLE;
      end else begin
        unique case (state)
          IDLE: begin
            if (!rxs) begin
              cnt      <= '0;
              bitcnt   <= '0;
              par_en   <= cfg_parity_en_i;
              par_type <= cfg_parity_type_i;
              stop2    <= cfg_stop_bits_i;
              state    <= START;
            end
          end
          WAIT_IDLE: begin
            if (rxs) state <= IDLE;
          end
          default: begin
            if (tick_i) begin
              cnt <= (cnt == LAST) ? '0 : cnt + CW'(1);
              if (cnt == MM1) smp0 <= rxs;
              if (cnt == MM)  smp1 <= rxs;
              unique case (state)
                START: begin
                  if (cnt == MP1 && vote) state <= IDLE;
                  else if (cnt == LAST)   state <= DATA;
                end
                DATA: begin
                  if (cnt == MP1)
                    shreg <= {vote, shreg[DATA_W-1:1]};
                  if (cnt == LAST) begin
                    if (bitcnt == LBIT) begin
                      bitcnt <= '0;
                      state  <= par_en ? PARITY : STOP1;
                    end else begin
                      bitcnt <= bitcnt + BW'(1);
                    end
                  end
                end
                PARITY: begin
                  if (cnt == MP1)  par_bit <= vote;
                  if (cnt == LAST) state   <= STOP1;
                end
                STOP1: begin
                  if (cnt == LAST) state <= STOP2;
                end
                default: ;
              endcase
            end
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_ovs.sv
// Scoreboard bench for uart_rx_ovs: directed frames queue
// expected results, a negedge monitor pops on every pulse.
module tb_uart_rx_ovs;

  localparam int DW  = 8;
  localparam int OVS = 16;
  localparam int M   = OVS / 2;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          valid;
    logic          perr;
    logic          ferr;
    logic          brk;
  } res_t;

  logic          clk = 1'b0;
  logic          arst_ni = 1'b0;
  logic          tick_i = 1'b1;
  logic          cfg_parity_en_i = 1'b0;
  logic          cfg_parity_type_i = 1'b0;
  logic          cfg_stop_bits_i = 1'b0;
  logic          rx_i = 1'b1;
  logic [DW-1:0] rx_data_o;
  logic          rx_data_valid_o;
  logic          rx_parity_err_o;
  logic          rx_frame_err_o;
  logic          rx_break_o;
  logic          rx_busy_o;

  int n_vec = 0;
  int n_err = 0;
  res_t exp_q[$];

  uart_rx_ovs #(.DATA_W(DW), .OVS(OVS)) dut (
    .clk_i             (clk),
    .arst_ni           (arst_ni),
    .tick_i            (tick_i),
    .cfg_parity_en_i   (cfg_parity_en_i),
    .cfg_parity_type_i (cfg_parity_type_i),
    .cfg_stop_bits_i   (cfg_stop_bits_i),
    .rx_i              (rx_i),
    .rx_data_o         (rx_data_o),
    .rx_data_valid_o   (rx_data_valid_o),
    .rx_parity_err_o   (rx_parity_err_o),
    .rx_frame_err_o    (rx_frame_err_o),
    .rx_break_o        (rx_break_o),
    .rx_busy_o         (rx_busy_o)
  );

  always #5 clk = ~clk;

  function automatic res_t outs();
    res_t r;
    r.data  = rx_data_o;
    r.valid = rx_data_valid_o;
    r.perr  = rx_parity_err_o;
    r.ferr  = rx_frame_err_o;
    r.brk   = rx_break_o;
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] got,
                       input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, got, want);
    end
  endtask

  // Monitor: every result pulse must match the head of the queue
  initial begin
    res_t got;
    res_t want;
    forever begin
      @(negedge clk);
      got = outs();
      if (got.valid | got.perr | got.ferr | got.brk) begin
        n_vec++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_pulse: got %h expected none", got);
        end else begin
          want = exp_q.pop_front();
          if (got !== want) begin
            n_err++;
            $display("FAIL frame_result: got %h expected %h", got, want);
          end
        end
      end
    end
  end

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b, input bit gl);
    for (int i = 0; i < OVS; i++) begin
      rx_i = (gl && i == M) ? ~b : b;
      wait_clk(1);
    end
  endtask

  task automatic send_frame(input logic [DW-1:0] d, input bit pen,
                            input logic pb, input int nstop,
                            input logic sv, input bit gl);
    send_bit(1'b0, gl);
    for (int i = 0; i < DW; i++) send_bit(d[i], gl);
    if (pen) send_bit(pb, gl);
    for (int s = 0; s < nstop; s++) send_bit(sv, gl);
  endtask

  function automatic res_t mk(input logic [DW-1:0] d, input logic v,
                              input logic p, input logic f,
                              input logic b);
    res_t r;
    r.data  = d;
    r.valid = v;
    r.perr  = p;
    r.ferr  = f;
    r.brk   = b;
    return r;
  endfunction

  initial begin
    #22;
    check("reset_outputs", {19'd0, outs(), rx_busy_o}, 32'd0);
    wait_clk(2);
    arst_ni = 1'b1;
    wait_clk(4);

    // Plain 8N1
    exp_q.push_back(mk(8'hA5, 1'b1, 1'b0, 1'b0, 1'b0));
    send_frame(8'hA5, 1'b0, 1'b0, 1, 1'b1, 1'b0);
    wait_clk(2 * OVS);

    // Even parity: 0x3C has four ones, so the correct parity bit is 0
    cfg_parity_en_i = 1'b1;
    exp_q.push_back(mk(8'h3C, 1'b1, 1'b0, 1'b0, 1'b0));
    send_frame(8'h3C, 1'b1, 1'b0, 1, 1'b1, 1'b0);
    wait_clk(2 * OVS);
    exp_q.push_back(mk(8'h3C, 1'b0, 1'b1, 1'b0, 1'b0));
    send_frame(8'h3C, 1'b1, 1'b1, 1, 1'b1, 1'b0);
    wait_clk(2 * OVS);
    cfg_parity_en_i = 1'b0;

    // False start: 3-tick low glitch
    rx_i = 1'b0;
    wait_clk(3);
    rx_i = 1'b1;
    wait_clk(1);
    check("false_start_busy_high", {31'd0, rx_busy_o}, 32'd1);
    wait_clk(M + 6);
    check("false_start_busy_drop", {31'd0, rx_busy_o}, 32'd0);
    wait_clk(2 * OVS);

    // Break: zero data, zero stop, line held low 20 bit times
    exp_q.push_back(mk(8'h00, 1'b0, 1'b0, 1'b1, 1'b1));
    send_frame(8'h00, 1'b0, 1'b0, 1, 1'b0, 1'b0);
    wait_clk(20 * OVS);
    check("break_busy_held", {31'd0, rx_busy_o}, 32'd1);
    rx_i = 1'b1;
    wait_clk(4);
    check("break_busy_release", {31'd0, rx_busy_o}, 32'd0);
    wait_clk(OVS);
    exp_q.push_back(mk(8'h55, 1'b1, 1'b0, 1'b0, 1'b0));
    send_frame(8'h55, 1'b0, 1'b0, 1, 1'b1, 1'b0);
    wait_clk(2 * OVS);

    // Two stop bits, back to back, one inverted tick per bit
    cfg_stop_bits_i = 1'b1;
    exp_q.push_back(mk(8'h00, 1'b1, 1'b0, 1'b0, 1'b0));
    exp_q.push_back(mk(8'hFF, 1'b1, 1'b0, 1'b0, 1'b0));
    send_frame(8'h00, 1'b0, 1'b0, 2, 1'b1, 1'b1);
    send_frame(8'hFF, 1'b0, 1'b0, 2, 1'b1, 1'b1);
    rx_i = 1'b1;
    wait_clk(2 * OVS);
    check("data_hold_after_ff", {24'd0, rx_data_o}, 32'h0000_00FF);
    cfg_stop_bits_i = 1'b0;

    // Reset in the middle of data bit 3
    send_bit(1'b0, 1'b0);
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b0);
    rx_i = 1'b1;
    wait_clk(M);
    check("mid_frame_busy", {31'd0, rx_busy_o}, 32'd1);
    arst_ni = 1'b0;
    #1;
    check("mid_frame_reset", {19'd0, outs(), rx_busy_o}, 32'd0);
    wait_clk(3);
    arst_ni = 1'b1;
    wait_clk(2 * OVS);
    check("post_reset_idle", {31'd0, rx_busy_o}, 32'd0);
    exp_q.push_back(mk(8'h5A, 1'b1, 1'b0, 1'b0, 1'b0));
    send_frame(8'h5A, 1'b0, 1'b0, 1, 1'b1, 1'b0);
    wait_clk(2 * OVS);

    check("scoreboard_drained", exp_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/uart_rx_ovs.md
# uart_rx_ovs

Parametrised oversampling UART receiver, the successor to the fixed 8-bit receiver in the UART datapath of the AXI-to-UART bridge. It supports configurable data width and oversampling factor, and synchronises the raw line. It takes a majority vote of three samples per bit, filters false start bits, and reports parity, framing and break conditions as separate pulses. It sits between the `rx_i` pad and the RX FIFO, and is clocked by the bridge clock, gated by a baud-rate oversampling tick.

## Interface
- `DATA_W`, default 8: data bits per frame, legal range 5..9, sent LSB first.
- `OVS`, default 16: ticks per bit period, even, legal range 4..32.
- `clk_i` input, 1 bit: clock.
- `arst_ni` input, 1 bit: asynchronous, active-low reset.
- `tick_i` input, 1 bit: oversampling enable pulse at OVS × baud. May be held high continuously.
- `cfg_parity_en_i` input, 1 bit: 1 = parity bit present.
- `cfg_parity_type_i` input, 1 bit: 0 = even, 1 = odd.
- `cfg_stop_bits_i` input, 1 bit: 0 = one stop bit, 1 = two stop bits.
- `rx_i` input, 1 bit: asynchronous serial line, idle high.
- `rx_data_o` output, DATA_W bits: last completed frame's data.
- `rx_data_valid_o` output, 1 bit: one-cycle pulse, error-free frame.
- `rx_parity_err_o` output, 1 bit: one-cycle pulse, parity mismatch.
- `rx_frame_err_o` output, 1 bit: one-cycle pulse, a stop bit sampled 0.
- `rx_break_o` output, 1 bit: one-cycle pulse, break detected.
- `rx_busy_o` output, 1 bit: high whenever the FSM is not in IDLE.

## Operation
- **Synchroniser.** `rx_i` passes through a 2-flop synchroniser (reset value 1). All logic uses the synchronised value `rxs`.
- **Counters.**
  - The tick counter is clog2(OVS) bits wide and advances only on `tick_i`. It wraps from OVS-1 to 0 and marks the end of a bit.
  - The bit counter is clog2(DATA_W+1) bits wide.
- **Majority vote.** Let M = OVS/2. Each bit is sampled at tick counts M-1, M and M+1; the bit value is the majority of the three samples. The vote is resolved at count M+1.
- **States:** IDLE, START, DATA, PARITY, STOP1, STOP2, WAIT_IDLE.
  - IDLE: on `rxs`==0, clear the tick counter and go to START. Latch the three cfg inputs here; they are ignored until the next IDLE.
  - START: if the vote = 1 (false start), go to IDLE with no output pulses. Otherwise, at count OVS-1, go to DATA.
  - DATA: shift the voted bit into bit index = bit counter. After DATA_W bits, at count OVS-1, go to PARITY if parity is enabled, else STOP1.
  - PARITY: store the voted bit. At count OVS-1, go to STOP1.
  - STOP1: the vote is resolved at M+1.
    - If two stop bits are configured and the vote = 1, wait until count OVS-1, then go to STOP2.
    - Otherwise the frame completes at the vote.
  - STOP2: the frame completes at its vote.
- **Frame completion.** Registered, in a single cycle:
  - `rx_data_o` ← assembled data, whatever the error status.
  - parity_err = parity enabled AND received parity ≠ (^data ^ type).
  - frame_err = any stop vote was 0. A 0 in STOP1 completes the frame immediately and skips STOP2.
  - break = frame_err AND all data bits 0 AND (parity disabled OR parity bit 0). Break pulses together with `rx_frame_err_o`.
  - `rx_data_valid_o` = NOT parity_err AND NOT frame_err.
  - Next state: frame_err → WAIT_IDLE; otherwise → IDLE. A new start can therefore begin half a bit after the stop midpoint.
- **WAIT_IDLE:** stay until `rxs`==1, then go to IDLE. A held-low line yields exactly one frame_err/break.

## Timing
- **Reset values:**
  - all pulses 0
  - `rx_data_o` = 0
  - `rx_busy_o` = 0
  - state = IDLE
  - counters = 0
- **Reset mid-frame:** immediate return to IDLE; no pulse is produced and `rx_data_o` clears to 0. Reset dominates every other event.
- **Start detection latency:** pad falling edge to START takes 2–3 clk (synchroniser plus the IDLE decision).
- **Completion latency:** result pulses appear 1 clk after the `tick_i` cycle that resolves the final stop vote. Measured from the start edge, this is (1+DATA_W+P+S-1)·OVS + M+1 ticks, where P = parity enable (0/1) and S = stop bits (1/2).
- **Pulse widths:** each pulse is exactly 1 clk wide, regardless of `tick_i` spacing.
- **Outside ticks:** with `tick_i` low, state and counters hold; only the synchroniser and the IDLE/WAIT_IDLE line checks run.
- **False start:** `rx_busy_o` drops at most M+2 ticks after entering START.

## Test plan
- DATA_W=8, OVS=16, `tick_i`=1, no parity, 1 stop, send 0xA5 → one `rx_data_valid_o` pulse, `rx_data_o`=0xA5, all error outputs 0.
- Even parity, send 0x3C with parity bit 0 → valid pulse. Resend with parity bit 1 → `rx_parity_err_o` pulse, no valid pulse, `rx_data_o`=0x3C.
- Line low for 3 ticks, then high → no pulses, and `rx_busy_o` returns to 0 within M+2 ticks.
- Send 0x00 with stop bit 0, line held low for 20 bit times → one pulse each of `rx_frame_err_o` and `rx_break_o`. `rx_busy_o` stays high until the line goes high, then a following 0x55 frame is received valid.
- Two stop bits, back-to-back frames 0x00 then 0xFF, with a single-tick inversion at count M of every bit → both frames valid with the correct data, confirming the majority vote.
- Assert `arst_ni` during data bit 3 → all outputs 0 immediately. After release, a 0x5A frame is received valid.
